// File: rtl/switch_event_pkg.sv
`default_nettype none
// ============================================================================
// Module      : switch_event_pkg
// Description : Shared constants and helpers for the switch event controller.
// Revision    : 1.0 - initial release
// ============================================================================
package switch_event_pkg;

    localparam logic [1:0] ADDR_DATA     = 2'd0;
    localparam logic [1:0] ADDR_EDGE_SEL = 2'd1;
    localparam logic [1:0] ADDR_IRQ_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP  = 2'd3;

    localparam int DEFAULT_WIDTH = 20;

    function automatic int cnt_width(input int db_ticks);
        int w;
        w = $clog2(db_ticks);
        return (w < 1) ? 1 : w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/switch_debounce_bit.sv
`default_nettype none
// ============================================================================
// Module      : switch_debounce_bit
// Description : Two-flop synchronizer and tick-driven debouncer for one switch.
// Revision    : 1.0 - initial release
// ============================================================================
module switch_debounce_bit
    import switch_event_pkg::*;
#(
    parameter int DB_TICKS = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic tick,
    input  logic in_bit,
    output logic stable
);

    localparam int              CNT_W      = cnt_width(DB_TICKS);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DB_TICKS - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_stable;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_sync1 <= in_bit;
            r_sync2 <= r_sync1;
            // The counter only advances while the input keeps disagreeing.
            if (tick) begin
                if (r_sync2 == r_stable) begin
                    r_cnt <= '0;
                end else if (r_cnt == C_CNT_LAST) begin
                    r_stable <= ~r_stable;
                    r_cnt    <= '0;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign stable = r_stable;

endmodule
`default_nettype wire

// File: rtl/switch_event_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : switch_event_ctrl
// Description : Debounced switch bank with edge capture and IRQ on Avalon-MM.
// Revision    : 1.0 - initial release
// ============================================================================
module switch_event_ctrl
    import switch_event_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int TICK_DIV = 50000,
    parameter int DB_TICKS = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam int                PRESC_W      = $clog2(TICK_DIV);
    localparam logic [PRESC_W-1:0] C_PRESC_LAST = PRESC_W'(TICK_DIV - 1);

    logic [PRESC_W-1:0] r_presc;
    logic               w_tick;
    logic [WIDTH-1:0]   w_stable;
    logic [WIDTH-1:0]   r_stable_d;
    logic [WIDTH-1:0]   r_edge_sel;
    logic [WIDTH-1:0]   r_irq_mask;
    logic [WIDTH-1:0]   r_edgecap;
    logic [WIDTH-1:0]   w_event;
    logic [WIDTH-1:0]   w_clr;
    logic               w_wr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_presc <= '0;
        end else if (r_presc == C_PRESC_LAST) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + PRESC_W'(1);
        end
    end

    assign w_tick = (r_presc == C_PRESC_LAST);

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        switch_debounce_bit #(
            .DB_TICKS (DB_TICKS)
        ) u_debounce (
            .clk     (clk),
            .reset_n (reset_n),
            .tick    (w_tick),
            .in_bit  (in_port[gi]),
            .stable  (w_stable[gi])
        );
    end

    if (WIDTH < 32) begin : g_unused_wdata
        logic w_unused;
        assign w_unused = &{1'b0, writedata[31:WIDTH]};
    end

    assign w_wr    = chipselect && !write_n;
    assign w_event = (w_stable & ~r_stable_d & r_edge_sel) |
                     (~w_stable & r_stable_d & ~r_edge_sel);
    assign w_clr   = (w_wr && address == ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;

    // A same-cycle event overrides a W1C so no edge is ever lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stable_d <= '0;
            r_edge_sel <= '0;
            r_irq_mask <= '0;
            r_edgecap  <= '0;
        end else begin
            r_stable_d <= w_stable;
            r_edgecap  <= (r_edgecap & ~w_clr) | w_event;
            if (w_wr && address == ADDR_EDGE_SEL) begin
                r_edge_sel <= writedata[WIDTH-1:0];
            end
            if (w_wr && address == ADDR_IRQ_MASK) begin
                r_irq_mask <= writedata[WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            case (address)
                ADDR_DATA:     readdata <= 32'(w_stable);
                ADDR_EDGE_SEL: readdata <= 32'(r_edge_sel);
                ADDR_IRQ_MASK: readdata <= 32'(r_irq_mask);
                default:       readdata <= 32'(r_edgecap);
            endcase
        end
    end

    assign irq = |(r_edgecap & r_irq_mask);

endmodule
`default_nettype wire

// File: tb/tb_switch_event_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_switch_event_ctrl
// Description : Directed and random bench for switch_event_ctrl with a model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_switch_event_ctrl;

    localparam int WIDTH    = 20;
    localparam int TICK_DIV = 4;
    localparam int DB_TICKS = 3;

    logic             clk        = 1'b0;
    logic             reset_n    = 1'b0;
    logic [1:0]       address    = 2'd0;
    logic             chipselect = 1'b0;
    logic             write_n    = 1'b1;
    logic [31:0]      writedata  = 32'd0;
    logic [31:0]      readdata;
    logic [WIDTH-1:0] in_port    = '0;
    logic             irq;

    int checks   = 0;
    int failures = 0;

    // Reference state, expressed as spec rules rather than RTL structure
    logic [WIDTH-1:0] m_s1, m_s2, m_st, m_std, m_es, m_mask, m_cap;
    logic [31:0]      m_rd;
    int               m_phase;
    int               m_run [WIDTH];

    switch_event_ctrl #(
        .WIDTH    (WIDTH),
        .TICK_DIV (TICK_DIV),
        .DB_TICKS (DB_TICKS)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_port    (in_port),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_st = '0; m_std = '0;
        m_es = '0; m_mask = '0; m_cap = '0; m_rd = '0;
        m_phase = 0;
        for (int i = 0; i < WIDTH; i++) m_run[i] = 0;
    endtask

    task automatic model_update();
        logic [WIDTH-1:0] ev;
        logic [WIDTH-1:0] clr;
        logic [31:0]      rd;
        bit               wr;
        if (!reset_n) begin
            model_reset();
            return;
        end
        case (address)
            2'd0:    rd = 32'(m_st);
            2'd1:    rd = 32'(m_es);
            2'd2:    rd = 32'(m_mask);
            default: rd = 32'(m_cap);
        endcase
        wr  = chipselect && !write_n;
        ev  = (m_st & ~m_std & m_es) | (~m_st & m_std & ~m_es);
        clr = (wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
        m_cap = (m_cap & ~clr) | ev;
        if (wr && address == 2'd1) m_es   = writedata[WIDTH-1:0];
        if (wr && address == 2'd2) m_mask = writedata[WIDTH-1:0];
        m_rd  = rd;
        m_std = m_st;
        if (m_phase == TICK_DIV - 1) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (m_s2[i] != m_st[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DB_TICKS) begin
                        m_st[i]  = ~m_st[i];
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
        end
        m_s2 = m_s1;
        m_s1 = in_port;
        m_phase = (m_phase + 1) % TICK_DIV;
    endtask

    task automatic cyc();
        @(posedge clk);
        model_update();
        #1;
        check("readdata_model", readdata, m_rd);
        check("irq_model", {31'd0, irq}, {31'd0, |(m_cap & m_mask)});
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b0;
        writedata  = d;
        cyc();
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'd0;
    endtask

    task automatic read_reg(input logic [1:0] a, output logic [31:0] d);
        address = a;
        cyc();
        d = readdata;
    endtask

    initial begin
        int          n;
        int          b;
        logic [31:0] d;
        model_reset();

        // Reset
        repeat (3) cyc();
        check("reset_readdata", readdata, 32'd0);
        check("reset_irq", {31'd0, irq}, 32'd0);
        reset_n = 1'b1;
        for (int a = 0; a < 4; a++) begin
            read_reg(2'(a), d);
            check("reset_reg_read", d, 32'd0);
        end

        // Clean press: stable latency 11..14, readdata one cycle later
        address = 2'd0;
        in_port = 20'h00001;
        n = 0;
        while (readdata[0] !== 1'b1 && n < 40) begin
            cyc();
            n++;
        end
        check("press_latency_in_range", 32'(n >= 12 && n <= 15), 32'd1);
        read_reg(2'd0, d);
        check("press_data", d, 32'h1);
        in_port = '0;
        repeat (20) cyc();
        bus_write(2'd3, 32'hFFFFF);

        // Bounce shorter than DB_TICKS ticks
        in_port[5] = 1'b1;
        repeat (8) cyc();
        in_port[5] = 1'b0;
        repeat (20) cyc();
        read_reg(2'd0, d);
        check("bounce_data", d, 32'd0);
        read_reg(2'd3, d);
        check("bounce_edgecap", d, 32'd0);
        check("bounce_irq", {31'd0, irq}, 32'd0);

        // Rising-edge capture and interrupt
        bus_write(2'd1, 32'h1);
        bus_write(2'd2, 32'h1);
        address = 2'd0;
        in_port[0] = 1'b1;
        n = 0;
        while (m_st[0] !== 1'b1 && n < 40) begin
            cyc();
            n++;
        end
        check("irq_before_capture", {31'd0, irq}, 32'd0);
        cyc();
        check("irq_after_capture", {31'd0, irq}, 32'd1);
        read_reg(2'd3, d);
        check("edgecap_rise", d, 32'h1);
        bus_write(2'd3, 32'h1);
        check("irq_after_w1c", {31'd0, irq}, 32'd0);
        in_port[0] = 1'b0;
        repeat (20) cyc();
        read_reg(2'd3, d);
        check("no_capture_on_fall", d, 32'd0);
        check("irq_stays_low", {31'd0, irq}, 32'd0);

        // Set beats clear on the same cycle
        bus_write(2'd1, 32'h0);
        bus_write(2'd2, 32'h8);
        in_port[3] = 1'b1;
        repeat (20) cyc();
        read_reg(2'd3, d);
        check("rise_not_captured", d, 32'd0);
        in_port[3] = 1'b0;
        n = 0;
        while (m_st[3] !== 1'b0 && n < 40) begin
            cyc();
            n++;
        end
        check("fall_seen_in_time", 32'(n < 40), 32'd1);
        bus_write(2'd3, 32'h8);
        read_reg(2'd3, d);
        check("collision_set_wins", d & 32'h8, 32'h8);
        check("collision_irq", {31'd0, irq}, 32'd1);
        bus_write(2'd3, 32'h8);
        check("collision_cleared_irq", {31'd0, irq}, 32'd0);

        // Reset during a debounce in progress
        in_port = 20'h00004;
        repeat (6) cyc();
        reset_n = 1'b0;
        repeat (2) cyc();
        reset_n = 1'b1;
        check("post_reset_data", readdata, 32'd0);
        bus_write(2'd1, 32'h4);
        address = 2'd0;
        n = 1;
        while (readdata[2] !== 1'b1 && n < 40) begin
            cyc();
            n++;
        end
        check("post_reset_latency", 32'(n >= 12 && n <= 15), 32'd1);
        cyc();
        read_reg(2'd3, d);
        check("post_reset_rise_capture", d, 32'h4);

        // Randomized traffic against the model
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 11) == 0) begin
                b = $urandom_range(0, WIDTH - 1);
                in_port[b] = ~in_port[b];
            end
            address   = 2'($urandom_range(0, 3));
            writedata = $urandom;
            if ($urandom_range(0, 7) == 0) begin
                chipselect = 1'b1;
                write_n    = 1'b0;
            end else begin
                chipselect = 1'($urandom_range(0, 1));
                write_n    = (chipselect == 1'b1) ? 1'b1 : 1'($urandom_range(0, 1));
            end
            cyc();
        end
        chipselect = 1'b0;
        write_n    = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
